text_edit_ctrl: RTL and testbench

- Sequences all writes into the 80x25 character buffer: accepts ASCII keystrokes over a valid/ready handshake and maintains the cursor.
- Issues one-cycle write strobes with address and data, and performs a cell-by-cell clear-screen sweep, replacing a single-cycle full-array reset.
- Sits between the keyboard/ASCII decoder and the text buffer write port; the VGA side reads the buffer independently.

---
 rtl/text_pkg.sv | 32 +++
 rtl/text_edit_ctrl_if.sv | 20 ++
 rtl/text_cursor_step.sv | 44 ++++
 rtl/text_edit_ctrl.sv | 153 +++++++++++++++
 tb/tb_text_edit_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// Shared constants, ASCII codes and state/step encodings for the text edit controller.
package text_pkg;

    localparam logic [6:0] COLS  = 7'd80;
    localparam logic [4:0] ROWS  = 5'd25;
    localparam logic [6:0] X_MAX = COLS - 7'd1;
    localparam logic [4:0] Y_MAX = ROWS - 5'd1;
    localparam logic [7:0] BLANK = 8'h20;

    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_ADV = 2'd0,
        OP_RET = 2'd1,
        OP_NL  = 2'd2
    } step_op_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_MIN) && (c <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/text_edit_ctrl_if.sv
// Keystroke handshake plus character-buffer write port.
interface text_edit_ctrl_if;
    logic       key_valid;
    logic [7:0] key_ascii;
    logic       key_ready;
    logic       wr_en;
    logic [6:0] wr_x;
    logic [4:0] wr_y;
    logic [7:0] wr_data;

    modport master (
        input  key_valid, key_ascii,
        output key_ready, wr_en, wr_x, wr_y, wr_data
    );

    modport slave (
        output key_valid, key_ascii,
        input  key_ready, wr_en, wr_x, wr_y, wr_data
    );
endinterface

// File: rtl/text_cursor_step.sv
// Combinational cursor stepping on the 80x25 grid: advance, retreat or newline with wrap.
module text_cursor_step
    import text_pkg::*;
(
    input  logic [6:0] x,
    input  logic [4:0] y,
    input  step_op_t   op,
    output logic [6:0] nx,
    output logic [4:0] ny
);

    always_comb begin
        nx = x;
        ny = y;
        case (op)
            OP_ADV: begin
                if (x == X_MAX) begin
                    nx = 7'd0;
                    ny = (y == Y_MAX) ? 5'd0 : y + 5'd1;
                end else begin
                    nx = x + 7'd1;
                end
            end
            // Retreat from (0,0) holds position; callers never request it there.
            OP_RET: begin
                if (x != 7'd0) begin
                    nx = x - 7'd1;
                end else if (y != 5'd0) begin
                    nx = X_MAX;
                    ny = y - 5'd1;
                end
            end
            OP_NL: begin
                nx = 7'd0;
                ny = (y == Y_MAX) ? 5'd0 : y + 5'd1;
            end
            default: begin
                nx = x;
                ny = y;
            end
        endcase
    end

endmodule

// File: rtl/text_edit_ctrl.sv
// Sequences keystroke writes and the cell-by-cell clear sweep into the text buffer, tracking the cursor.
module text_edit_ctrl
    import text_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    text_edit_ctrl_if.master  bus,
    input  logic              clear_req,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic              busy,
    output logic              clear_done
);

    state_t     state, state_nxt;
    logic       key_ready_c, wr_en_c, done_c;
    logic [6:0] wr_x_r;
    logic [4:0] wr_y_r;
    logic [7:0] wr_data_r;
    logic       is_bs_r;

    logic       accept, key_print, key_bs, key_cr, at_origin, sweep_last;
    step_op_t   cur_op;
    logic [6:0] cur_nx, ret_nx, swp_nx;
    logic [4:0] cur_ny, ret_ny, swp_ny;

    assign key_print  = is_printable(bus.key_ascii);
    assign key_bs     = (bus.key_ascii == ASCII_BS);
    assign key_cr     = (bus.key_ascii == ASCII_CR);
    assign at_origin  = (cursor_x == 7'd0) && (cursor_y == 5'd0);
    assign sweep_last = (wr_x_r == X_MAX) && (wr_y_r == Y_MAX);
    assign accept     = bus.key_valid && key_ready_c;
    assign cur_op     = (state == ST_WRITE) ? OP_ADV : OP_NL;

    text_cursor_step u_cur_step (
        .x(cursor_x), .y(cursor_y), .op(cur_op), .nx(cur_nx), .ny(cur_ny)
    );

    text_cursor_step u_ret_step (
        .x(cursor_x), .y(cursor_y), .op(OP_RET), .nx(ret_nx), .ny(ret_ny)
    );

    // The sweep walks the write address itself, so the same advance wrap applies.
    text_cursor_step u_swp_step (
        .x(wr_x_r), .y(wr_y_r), .op(OP_ADV), .nx(swp_nx), .ny(swp_ny)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        key_ready_c = 1'b0;
        wr_en_c     = 1'b0;
        done_c      = 1'b0;
        case (state)
            ST_IDLE: begin
                key_ready_c = reset_n && !clear_req;
                if (clear_req) begin
                    state_nxt = ST_CLEAR;
                end else if (bus.key_valid) begin
                    if (key_print || (key_bs && !at_origin)) begin
                        state_nxt = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                wr_en_c   = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                wr_en_c = 1'b1;
                if (sweep_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_c    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cursor_x  <= 7'd0;
            cursor_y  <= 5'd0;
            wr_x_r    <= 7'd0;
            wr_y_r    <= 5'd0;
            wr_data_r <= 8'h00;
            is_bs_r   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        wr_x_r    <= 7'd0;
                        wr_y_r    <= 5'd0;
                        wr_data_r <= BLANK;
                    end else if (accept) begin
                        if (key_print) begin
                            wr_x_r    <= cursor_x;
                            wr_y_r    <= cursor_y;
                            wr_data_r <= bus.key_ascii;
                            is_bs_r   <= 1'b0;
                        end else if (key_bs && !at_origin) begin
                            wr_x_r    <= ret_nx;
                            wr_y_r    <= ret_ny;
                            wr_data_r <= BLANK;
                            is_bs_r   <= 1'b1;
                        end else if (key_cr) begin
                            cursor_x <= cur_nx;
                            cursor_y <= cur_ny;
                        end
                    end
                end
                ST_WRITE: begin
                    if (is_bs_r) begin
                        cursor_x <= wr_x_r;
                        cursor_y <= wr_y_r;
                    end else begin
                        cursor_x <= cur_nx;
                        cursor_y <= cur_ny;
                    end
                end
                ST_CLEAR: begin
                    wr_x_r <= swp_nx;
                    wr_y_r <= swp_ny;
                    if (sweep_last) begin
                        cursor_x <= 7'd0;
                        cursor_y <= 5'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.key_ready = key_ready_c;
    assign bus.wr_en     = wr_en_c;
    assign bus.wr_x      = wr_x_r;
    assign bus.wr_y      = wr_y_r;
    assign bus.wr_data   = wr_data_r;
    assign busy          = (state != ST_IDLE);
    assign clear_done    = done_c;

endmodule

// File: tb/tb_text_edit_ctrl.sv
// Directed bench for text_edit_ctrl: keystroke writes, cursor wrap, backspace/CR, clear sweep and reset abort.
module tb_text_edit_ctrl;

    logic       clk;
    logic       reset_n;
    logic       clear_req;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;
    logic       busy;
    logic       clear_done;

    int         errors = 0;
    int         checks = 0;
    int         n;
    int         bad;
    logic [6:0] lx;
    logic [4:0] ly;

    text_edit_ctrl_if ifc ();

    text_edit_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (ifc.master),
        .clear_req  (clear_req),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .busy       (busy),
        .clear_done (clear_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a);
        ifc.key_valid = 1'b1;
        ifc.key_ascii = a;
        tick();
        ifc.key_valid = 1'b0;
    endtask

    task automatic type_n(input logic [7:0] a, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            send(a);
            tick();
        end
    endtask

    task automatic cr_n(input int cnt);
        for (int i = 0; i < cnt; i++) send(8'h0D);
    endtask

    task automatic step_write(input string tag, input logic [7:0] a,
                              input logic [6:0] ex, input logic [4:0] ey, input logic [7:0] ed,
                              input logic [6:0] cx, input logic [4:0] cy);
        send(a);
        chk({tag, " wr_en"}, ifc.wr_en, 1);
        chk({tag, " wr_x"}, ifc.wr_x, ex);
        chk({tag, " wr_y"}, ifc.wr_y, ey);
        chk({tag, " wr_data"}, ifc.wr_data, ed);
        chk({tag, " key_ready low"}, ifc.key_ready, 0);
        chk({tag, " busy"}, busy, 1);
        tick();
        chk({tag, " wr_en off"}, ifc.wr_en, 0);
        chk({tag, " cursor_x"}, cursor_x, cx);
        chk({tag, " cursor_y"}, cursor_y, cy);
        chk({tag, " key_ready back"}, ifc.key_ready, 1);
    endtask

    task automatic step_nowrite(input string tag, input logic [7:0] a,
                                input logic [6:0] cx, input logic [4:0] cy);
        send(a);
        chk({tag, " no wr_en"}, ifc.wr_en, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " key_ready"}, ifc.key_ready, 1);
        chk({tag, " cursor_x"}, cursor_x, cx);
        chk({tag, " cursor_y"}, cursor_y, cy);
    endtask

    initial begin
        reset_n       = 1'b0;
        clear_req     = 1'b0;
        ifc.key_valid = 1'b0;
        ifc.key_ascii = 8'h00;
        #2;
        chk("rst key_ready", ifc.key_ready, 0);
        chk("rst wr_en", ifc.wr_en, 0);
        chk("rst wr_x", ifc.wr_x, 0);
        chk("rst wr_y", ifc.wr_y, 0);
        chk("rst wr_data", ifc.wr_data, 0);
        chk("rst cursor_x", cursor_x, 0);
        chk("rst cursor_y", cursor_y, 0);
        chk("rst clear_done", clear_done, 0);
        chk("rst busy", busy, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("post-rst key_ready", ifc.key_ready, 1);

        step_write("A@0,0", 8'h41, 7'd0, 5'd0, 8'h41, 7'd1, 5'd0);

        cr_n(3);
        type_n(8'h78, 79);
        step_write("z@79,3", 8'h7A, 7'd79, 5'd3, 8'h7A, 7'd0, 5'd4);
        cr_n(20);
        type_n(8'h78, 79);
        step_write("z@79,24", 8'h7A, 7'd79, 5'd24, 8'h7A, 7'd0, 5'd0);

        cr_n(1);
        step_write("bs@0,1", 8'h08, 7'd79, 5'd0, 8'h20, 7'd79, 5'd0);
        cr_n(25);
        chk("cr x25 cursor_x", cursor_x, 0);
        chk("cr x25 cursor_y", cursor_y, 0);
        step_nowrite("bs@0,0", 8'h08, 7'd0, 5'd0);
        type_n(8'h61, 2);
        step_write("bs@2,0", 8'h08, 7'd1, 5'd0, 8'h20, 7'd1, 5'd0);

        cr_n(24);
        type_n(8'h6B, 17);
        chk("pre-cr cursor_x", cursor_x, 17);
        chk("pre-cr cursor_y", cursor_y, 24);
        step_nowrite("cr@17,24", 8'h0D, 7'd0, 5'd0);
        step_nowrite("bel dropped", 8'h07, 7'd0, 5'd0);

        cr_n(5);
        type_n(8'h6D, 5);
        chk("pre-clear cursor_x", cursor_x, 5);
        chk("pre-clear cursor_y", cursor_y, 5);
        clear_req     = 1'b1;
        ifc.key_valid = 1'b1;
        ifc.key_ascii = 8'h51;
        #1;
        chk("clear prio key_ready", ifc.key_ready, 0);
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        chk("clear busy", busy, 1);
        chk("clear first wr_en", ifc.wr_en, 1);
        chk("clear first wr_x", ifc.wr_x, 0);
        chk("clear first wr_y", ifc.wr_y, 0);
        chk("clear key_ready", ifc.key_ready, 0);
        n   = 0;
        bad = 0;
        lx  = 7'd0;
        ly  = 5'd0;
        while (ifc.wr_en && n < 2100) begin
            if (ifc.wr_data !== 8'h20) bad++;
            lx = ifc.wr_x;
            ly = ifc.wr_y;
            n++;
            tick();
        end
        chk("clear cycles", n, 2000);
        chk("clear nonblank", bad, 0);
        chk("clear last wr_x", lx, 79);
        chk("clear last wr_y", ly, 24);
        chk("done pulse", clear_done, 1);
        chk("done busy", busy, 1);
        chk("done key_ready", ifc.key_ready, 0);
        chk("done cursor_x", cursor_x, 0);
        chk("done cursor_y", cursor_y, 0);
        tick();
        chk("done one cycle", clear_done, 0);
        chk("idle after done", busy, 0);
        chk("pending key_ready", ifc.key_ready, 1);
        tick();
        ifc.key_valid = 1'b0;
        chk("pending wr_en", ifc.wr_en, 1);
        chk("pending wr_x", ifc.wr_x, 0);
        chk("pending wr_y", ifc.wr_y, 0);
        chk("pending wr_data", ifc.wr_data, 8'h51);
        tick();
        chk("pending cursor_x", cursor_x, 1);
        chk("pending cursor_y", cursor_y, 0);

        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("abort sweep start", ifc.wr_en, 1);
        repeat (999) @(posedge clk);
        #1;
        chk("abort sweep running", ifc.wr_en, 1);
        chk("abort sweep row", ifc.wr_y, 12);
        reset_n = 1'b0;
        #1;
        chk("abort wr_en", ifc.wr_en, 0);
        chk("abort cursor_x", cursor_x, 0);
        chk("abort cursor_y", cursor_y, 0);
        chk("abort busy", busy, 0);
        chk("abort key_ready", ifc.key_ready, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("release key_ready", ifc.key_ready, 1);
        chk("release busy", busy, 0);
        chk("release wr_en", ifc.wr_en, 0);
        step_write("B after abort", 8'h42, 7'd0, 5'd0, 8'h42, 7'd1, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
